// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration bus: address field layout,
// module flag codes, the buffered word type and the sequencer state enum.
package cfg_pkg;

  localparam logic [15:0] CFG_FLAG_CLB = 16'd4;
  localparam logic [15:0] CFG_FLAG_CB1 = 16'd5;
  localparam logic [15:0] CFG_FLAG_CB0 = 16'd6;
  localparam logic [15:0] CFG_FLAG_SB  = 16'd7;

  localparam int TILE_ID_LSB = 0;
  localparam int TILE_ID_MSB = 15;
  localparam int FLAG_LSB    = 16;
  localparam int FLAG_MSB    = 31;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } cfg_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } seq_state_e;

endpackage

// File: rtl/config_word_fifo.sv
// Synchronous DEPTH x cfg_word_t FIFO with occupancy count; reset_ni is a
// synchronous active-low reset. Head word is readable without a pop.
module config_word_fifo
  import cfg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push_i,
  input  cfg_word_t                wdata_i,
  input  logic                     pop_i,
  output cfg_word_t                rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  cfg_word_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);
  assign do_push  = push_i && !full;
  assign do_pop   = pop_i && !empty_o;
  assign rdata_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_next_o = count_q;
    if (do_push && !do_pop) begin
      count_next_o = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_next_o = count_q - (AW+1)'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/config_bus_sequencer.sv
// Drains buffered (addr,data) words onto the tile config bus, holding each
// word HOLD_CYCLES cycles followed by GAP_CYCLES cycles of IDLE_ADDR.
module config_bus_sequencer
  import cfg_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          HOLD_CYCLES = 1,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = DEPTH[AW:0];
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int            GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_e     state_q, state_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           last_q, last_d;
  logic           done_q, done_d;
  logic [15:0]    word_count_q, word_count_d;
  logic           in_ready_q;
  logic           busy_q, busy_d;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_empty;
  cfg_word_t      fifo_head;
  cfg_word_t      fifo_wdata;
  logic [AW:0]    fifo_count_next;
  logic           try_pop;

  assign fifo_push  = in_valid && in_ready_q;
  assign fifo_wdata = '{addr: in_addr, data: in_data, last: in_last};

  config_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .reset_ni     (reset),
    .push_i       (fifo_push),
    .wdata_i      (fifo_wdata),
    .pop_i        (fifo_pop),
    .rdata_o      (fifo_head),
    .empty_o      (fifo_empty),
    .count_next_o (fifo_count_next)
  );

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    last_d       = last_q;
    done_d       = 1'b0;
    word_count_d = word_count_q;
    fifo_pop     = 1'b0;
    try_pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: try_pop = 1'b1;
      ST_ISSUE: begin
        if (hold_cnt_q == '0) begin
          addr_d       = IDLE_ADDR;
          data_d       = '0;
          word_count_d = word_count_q + 16'd1;
          if (GAP_CYCLES == 0) begin
            done_d  = last_q;
            try_pop = 1'b1;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          done_d  = last_q;
          try_pop = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving a gap (or IDLE) pops directly so consecutive words are spaced
    // by exactly GAP_CYCLES idle cycles, with no extra IDLE cycle.
    if (try_pop) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        addr_d     = fifo_head.addr;
        data_d     = fifo_head.data;
        last_d     = fifo_head.last;
        hold_cnt_d = HOLD_LOAD;
        state_d    = ST_ISSUE;
      end else begin
        addr_d  = IDLE_ADDR;
        data_d  = '0;
        state_d = ST_IDLE;
      end
    end

    busy_d = (fifo_count_next != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      addr_q       <= IDLE_ADDR;
      data_q       <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
      in_ready_q   <= (fifo_count_next != FULL_CNT);
      busy_q       <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign config_addr = addr_q;
  assign config_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_config_bus_sequencer.sv
// Directed bench for config_bus_sequencer: four instances with different
// hold/gap settings, hand-computed timelines plus a bus scoreboard.
module tb_config_bus_sequencer;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        in_valid [N];
  logic        in_ready [N];
  logic [31:0] in_addr  [N];
  logic [31:0] in_data  [N];
  logic        in_last  [N];
  logic [31:0] cfg_addr [N];
  logic [31:0] cfg_data [N];
  logic        busy     [N];
  logic        done     [N];
  logic [15:0] wcnt     [N];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          act   = 0;
  logic [64:0] expq [$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    config_bus_sequencer #(
      .DEPTH       (8),
      .HOLD_CYCLES ((g == 1) ? 2 : ((g == 2) ? 20 : 1)),
      .GAP_CYCLES  ((g == 3) ? 0 : 1),
      .IDLE_ADDR   (32'h0000_0000)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in_addr     (in_addr[g]),
      .in_data     (in_data[g]),
      .in_last     (in_last[g]),
      .config_addr (cfg_addr[g]),
      .config_data (cfg_data[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .word_count  (wcnt[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hold_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 20 : 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic l, output int acc);
    bit rdy;
    rdy = 1'b0;
    in_valid[i] = 1'b1;
    in_addr[i]  = a;
    in_data[i]  = d;
    in_last[i]  = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rdy = in_ready[i];
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    in_valid[i] = 1'b0;
    if (rdy) begin
      expq.push_back({a, d, l});
      acc = cyc;
    end else begin
      chk("push_timeout", 32'd0, 32'd1);
      acc = -1;
    end
  endtask

  // Scoreboard: every non-idle bus run must match the next pushed word and
  // last exactly HOLD_CYCLES cycles.
  int          run_len = 0;
  logic [31:0] cur_a, cur_d;
  logic [64:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      run_len = 0;
      expq.delete();
    end else if (cfg_addr[act] != 32'h0) begin
      if (run_len == 0 || cfg_addr[act] != cur_a || cfg_data[act] != cur_d) begin
        if (run_len != 0) chk("sb_hold", run_len, hold_of(act));
        if (expq.size() == 0) begin
          chk("sb_unexpected", cfg_addr[act], 32'h0);
        end else begin
          e = expq.pop_front();
          chk("sb_addr", cfg_addr[act], e[64:33]);
          chk("sb_data", cfg_data[act], e[32:1]);
        end
        cur_a   = cfg_addr[act];
        cur_d   = cfg_data[act];
        run_len = 1;
      end else begin
        run_len++;
      end
    end else begin
      if (run_len != 0) chk("sb_hold", run_len, hold_of(act));
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t, t1, t2, bound;
    logic [31:0] ea;
    bit any_done;

    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      in_addr[i]  = '0;
      in_data[i]  = '0;
      in_last[i]  = 1'b0;
    end

    // Reset held with in_valid asserted
    act = 0;
    in_valid[0] = 1'b1;
    in_addr[0]  = 32'h0004_00AA;
    in_data[0]  = 32'hDEAD_BEEF;
    repeat (3) step();
    chk("rst_addr",  cfg_addr[0], 32'h0);
    chk("rst_data",  cfg_data[0], 32'h0);
    chk("rst_ready", in_ready[0], 1'b0);
    chk("rst_wcnt",  wcnt[0], 16'd0);
    chk("rst_busy",  busy[0], 1'b0);
    chk("rst_done",  done[0], 1'b0);
    reset = 1'b1;
    step();
    chk("rst_ready_rel", in_ready[0], 1'b1);
    in_valid[0] = 1'b0;
    step();
    chk("rst_no_capture", busy[0], 1'b0);

    // Single word, default hold/gap
    push(0, 32'h0007_0003, 32'h15, 1'b1, t);
    wait_to(t + 1);
    chk("t2_addr", cfg_addr[0], 32'h0007_0003);
    chk("t2_data", cfg_data[0], 32'h15);
    chk("t2_busy", busy[0], 1'b1);
    wait_to(t + 2);
    chk("t2_idle", cfg_addr[0], 32'h0);
    chk("t2_wcnt", wcnt[0], 16'd1);
    chk("t2_done_early", done[0], 1'b0);
    wait_to(t + 3);
    chk("t2_done", done[0], 1'b1);
    chk("t2_busy_end", busy[0], 1'b0);
    wait_to(t + 4);
    chk("t2_done_pulse", done[0], 1'b0);

    // Burst of three, HOLD=2 GAP=1, last only on the third
    do_reset();
    act = 1;
    push(1, 32'h0005_0001, 32'hA1, 1'b0, t);
    push(1, 32'h0006_0002, 32'hB2, 1'b0, t1);
    push(1, 32'h0007_0003, 32'hC3, 1'b1, t2);
    chk("t3_back2back", t2 - t, 2);
    for (int k = 3; k <= 11; k++) begin
      wait_to(t + k);
      case (k)
        4, 5:    ea = 32'h0006_0002;
        7, 8:    ea = 32'h0007_0003;
        default: ea = 32'h0;
      endcase
      chk("t3_addr", cfg_addr[1], ea);
      chk("t3_done", done[1], (k == 10) ? 1'b1 : 1'b0);
    end
    chk("t3_wcnt", wcnt[1], 16'd3);
    chk("t3_busy", busy[1], 1'b0);

    // Fill with the FSM stalled by HOLD=20
    do_reset();
    act = 2;
    push(2, 32'h0004_0000, 32'h00, 1'b0, t);
    for (int i = 1; i < 9; i++) push(2, 32'h0004_0000 + i, i * 32'h11, 1'b0, t1);
    chk("t4_fill_cycle", t1 - t, 8);
    chk("t4_full_ready", in_ready[2], 1'b0);
    push(2, 32'h0004_0009, 32'h99, 1'b1, t2);
    chk("t4_tenth_accept", t2 - t, 23);
    bound = 0;
    while (busy[2] && bound < 400) begin
      step();
      bound++;
    end
    chk("t4_drain_timeout", (bound < 400) ? 1'b1 : 1'b0, 1'b1);
    chk("t4_wcnt", wcnt[2], 16'd10);
    chk("t4_sb_empty", expq.size(), 0);

    // GAP_CYCLES=0: back-to-back issue
    do_reset();
    act = 3;
    push(3, 32'h0005_0010, 32'h1234, 1'b0, t);
    push(3, 32'h0006_0011, 32'h5678, 1'b1, t1);
    wait_to(t + 1);
    chk("t5_first", cfg_addr[3], 32'h0005_0010);
    wait_to(t + 2);
    chk("t5_second", cfg_addr[3], 32'h0006_0011);
    chk("t5_second_data", cfg_data[3], 32'h5678);
    chk("t5_no_done", done[3], 1'b0);
    wait_to(t + 3);
    chk("t5_idle", cfg_addr[3], 32'h0);
    chk("t5_done", done[3], 1'b1);
    chk("t5_wcnt", wcnt[3], 16'd2);

    // Reset in the middle of a HOLD=20 issue
    do_reset();
    act = 2;
    push(2, 32'h0007_0020, 32'hF00D, 1'b1, t);
    push(2, 32'h0007_0021, 32'hBEEF, 1'b1, t1);
    wait_to(t + 5);
    chk("t6_issuing", cfg_addr[2], 32'h0007_0020);
    reset = 1'b0;
    step();
    chk("t6_abort_addr", cfg_addr[2], 32'h0);
    chk("t6_abort_busy", busy[2], 1'b0);
    chk("t6_abort_done", done[2], 1'b0);
    chk("t6_abort_wcnt", wcnt[2], 16'd0);
    reset = 1'b1;
    any_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      any_done = any_done | done[2];
    end
    chk("t6_never_done", any_done, 1'b0);
    chk("t6_fifo_empty", busy[2], 1'b0);
    chk("t6_bus_idle", cfg_addr[2], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
